// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
// Holds the FSM state encoding, default wait-state latencies and the counter-width rule.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_BITS     = 10;
  localparam int unsigned DEF_READ_LATENCY  = 3;
  localparam int unsigned DEF_WRITE_LATENCY = 2;
  localparam int unsigned DATA_W            = 32;

  // Wait-state counter width: clog2 of the longest latency, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_lat);
    return (max_lat <= 2) ? 1 : $clog2(max_lat);
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port word array: synchronous write, synchronous (registered) read.
// The read port samples addr on every edge, so dout follows addr one cycle later.
module data_ram_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    din,
  output logic [DATA_W-1:0]    dout
);

  logic [DATA_W-1:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
    dout <= mem_q[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts word loads/stores from the MEM stage,
// inserts configurable wait states and raises ram_stall until the access completes.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
  parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_cs,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic              mem_en,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_din,
  output logic [DATA_W-1:0] mem_dout,
  output logic              ram_stall
);

  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = cnt_width(MAX_LAT);
  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(READ_LATENCY - 2);
  localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WRITE_LATENCY - 2);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]     din_q, din_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  wr_q, wr_d;

  logic                  req_c;
  logic                  ram_we_c;
  logic [ADDR_BITS-1:0]  live_addr_c;
  logic [ADDR_BITS-1:0]  ram_addr_c;
  logic [DATA_W-1:0]     ram_din_c;
  logic [DATA_W-1:0]     ram_dout;
  logic                  unused_addr_bits;

  assign live_addr_c      = mem_addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS+2], mem_addr[1:0]};
  assign req_c            = ram_cs & (mem_ren | mem_wen);

  // In IDLE the live request drives the array so a 1-cycle access can complete at the accepting edge.
  assign ram_addr_c = (state_q == ST_IDLE) ? live_addr_c : addr_q;
  assign ram_din_c  = (state_q == ST_IDLE) ? mem_din     : din_q;

  // The array's read register already holds the load result while in DONE; dout_q keeps it afterwards.
  assign mem_dout = ((state_q == ST_DONE) && !wr_q) ? ram_dout : dout_q;

  data_ram_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk (clk),
    .we  (ram_we_c),
    .addr(ram_addr_c),
    .din (ram_din_c),
    .dout(ram_dout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    din_d     = din_q;
    wr_d      = wr_q;
    dout_d    = dout_q;
    ram_we_c  = 1'b0;
    ram_stall = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ram_stall = req_c;
        if (req_c) begin
          addr_d = live_addr_c;
          din_d  = mem_din;
          wr_d   = mem_wen;
          if (mem_wen) begin
            if (WRITE_LATENCY == 1) begin
              ram_we_c = 1'b1;
              state_d  = ST_DONE;
            end else begin
              cnt_d   = WR_CNT_INIT;
              state_d = ST_BUSY;
            end
          end else if (READ_LATENCY == 1) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = RD_CNT_INIT;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // Dropping ram_cs is a pipeline flush: release the stall and abandon the access.
        ram_stall = ram_cs;
        if (!ram_cs) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          ram_we_c = wr_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (mem_en) begin
          state_d = ST_IDLE;
          if (!wr_q) begin
            dout_d = ram_dout;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rst) begin
      ram_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus a randomized
// back-to-back stream checked against a word-array reference model.
module tb_data_mem_responder;

  localparam int unsigned ADDR_BITS = 10;
  localparam int unsigned RD_LAT    = 3;
  localparam int unsigned WR_LAT    = 2;
  localparam int unsigned DEPTH     = 2**ADDR_BITS;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_cs;
  logic        mem_ren;
  logic        mem_wen;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        ram_stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_dout;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_BITS    (ADDR_BITS),
    .READ_LATENCY (RD_LAT),
    .WRITE_LATENCY(WR_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ram_cs   (ram_cs),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .ram_stall(ram_stall)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int unsigned widx(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  // Reference behaviour: a store writes the word, a load (store wins if both) reads it.
  task automatic model_access(input logic ren, input logic wen, input logic [31:0] a,
                              input logic [31:0] d);
    if (wen) model_mem[widx(a)] = d;
    else if (ren) model_dout = model_mem[widx(a)];
  endtask

  // Called at posedge+1; issues one access with mem_en=1 and returns at posedge+1 after DONE.
  task automatic access(input logic ren, input logic wen, input logic [31:0] a,
                        input logic [31:0] d, output int stalls, output logic [31:0] dout);
    ram_cs = 1'b1; mem_ren = ren; mem_wen = wen; mem_addr = a; mem_din = d; mem_en = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (ram_stall === 1'b1 && stalls < 16) begin
      stalls++;
      @(negedge clk);
    end
    dout = mem_dout;
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    ram_cs = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_cs = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_en = 1'b1;
    mem_addr = '0; mem_din = '0;
    #3;
    n_checks++;
    if (ram_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", ram_stall); end
    n_checks++;
    if (mem_dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", mem_dout); end
    @(negedge clk); rst = 1'b0; model_dout = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int s; logic [31:0] d;
    access(1'b0, 1'b1, 32'h40, 32'h12345678, s, d); model_access(1'b0, 1'b1, 32'h40, 32'h12345678);
    n_checks++;
    if (s != 2) begin n_fail++; $display("FAIL basic_store_stall: got %0d expected 2", s); end
    n_checks++;
    if (d !== model_dout) begin n_fail++; $display("FAIL basic_store_dout: got %h expected %h", d, model_dout); end
    access(1'b1, 1'b0, 32'h40, 32'h0, s, d); model_access(1'b1, 1'b0, 32'h40, 32'h0);
    n_checks++;
    if (s != 3) begin n_fail++; $display("FAIL basic_load_stall: got %0d expected 3", s); end
    n_checks++;
    if (d !== 32'h12345678) begin n_fail++; $display("FAIL basic_load_data: got %h expected 12345678", d); end
  endtask

  task automatic test_wrap();
    int s; logic [31:0] d;
    access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, s, d); model_access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'h1043, 32'h0, s, d); model_access(1'b1, 1'b0, 32'h1043, 32'h0);
    n_checks++;
    if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap_load_data: got %h expected cafef00d", d); end
    n_checks++;
    if (s != 3) begin n_fail++; $display("FAIL wrap_load_stall: got %0d expected 3", s); end
  endtask

  task automatic test_flush();
    int s; logic [31:0] d;
    access(1'b0, 1'b1, 32'h80, 32'h11112222, s, d); model_access(1'b0, 1'b1, 32'h80, 32'h11112222);
    go_idle();
    ram_cs = 1'b1; mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = 32'h80; mem_din = 32'hDEAD;
    @(negedge clk);
    n_checks++;
    if (ram_stall !== 1'b1) begin n_fail++; $display("FAIL flush_first_stall: got %b expected 1", ram_stall); end
    @(posedge clk); #1; ram_cs = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ram_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall_drop: got %b expected 0", ram_stall); end
    n_checks++;
    if (mem_dout !== model_dout) begin n_fail++; $display("FAIL flush_dout: got %h expected %h", mem_dout, model_dout); end
    @(posedge clk); #1; mem_wen = 1'b0;
    access(1'b1, 1'b0, 32'h80, 32'h0, s, d); model_access(1'b1, 1'b0, 32'h80, 32'h0);
    n_checks++;
    if (d !== 32'h11112222) begin n_fail++; $display("FAIL flush_old_data: got %h expected 11112222", d); end
  endtask

  task automatic test_freeze();
    int s; logic [31:0] d;
    go_idle();
    ram_cs = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h40; mem_en = 1'b0;
    model_access(1'b1, 1'b0, 32'h40, 32'h0);
    s = 0;
    @(negedge clk);
    while (ram_stall === 1'b1 && s < 16) begin s++; @(negedge clk); end
    n_checks++;
    if (s != 3) begin n_fail++; $display("FAIL freeze_load_stall: got %0d expected 3", s); end
    n_checks++;
    if (mem_dout !== model_dout) begin n_fail++; $display("FAIL freeze_load_data: got %h expected %h", mem_dout, model_dout); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (ram_stall !== 1'b0 || mem_dout !== model_dout) begin
        n_fail++;
        $display("FAIL freeze_hold[%0d]: stall %b dout %h expected stall 0 dout %h", i, ram_stall, mem_dout, model_dout);
      end
    end
    @(posedge clk); #1; mem_en = 1'b1;
    go_idle();
    access(1'b1, 1'b0, 32'h40, 32'h0, s, d); model_access(1'b1, 1'b0, 32'h40, 32'h0);
    n_checks++;
    if (s != 3) begin n_fail++; $display("FAIL freeze_next_stall: got %0d expected 3", s); end
    n_checks++;
    if (d !== model_dout) begin n_fail++; $display("FAIL freeze_array_intact: got %h expected %h", d, model_dout); end
  endtask

  task automatic test_async_reset();
    int s; logic [31:0] d;
    access(1'b0, 1'b1, 32'h10, 32'h00007777, s, d); model_access(1'b0, 1'b1, 32'h10, 32'h00007777);
    go_idle();
    ram_cs = 1'b1; mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = 32'h10; mem_din = 32'hBEEF;
    @(negedge clk);
    @(posedge clk); #2;
    n_checks++;
    if (ram_stall !== 1'b1) begin n_fail++; $display("FAIL areset_busy_stall: got %b expected 1", ram_stall); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ram_stall !== 1'b0) begin n_fail++; $display("FAIL areset_stall: got %b expected 0", ram_stall); end
    n_checks++;
    if (mem_dout !== 32'h0) begin n_fail++; $display("FAIL areset_dout: got %h expected 0", mem_dout); end
    ram_cs = 1'b0; mem_wen = 1'b0;
    @(negedge clk); rst = 1'b0; model_dout = '0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h10, 32'h0, s, d); model_access(1'b1, 1'b0, 32'h10, 32'h0);
    n_checks++;
    if (d !== 32'h00007777) begin n_fail++; $display("FAIL areset_store_dropped: got %h expected 00007777", d); end
  endtask

  task automatic test_both_enables();
    int s; logic [31:0] d;
    access(1'b1, 1'b1, 32'h20, 32'h55, s, d); model_access(1'b1, 1'b1, 32'h20, 32'h55);
    n_checks++;
    if (s != 2) begin n_fail++; $display("FAIL both_stall: got %0d expected 2", s); end
    n_checks++;
    if (d !== model_dout) begin n_fail++; $display("FAIL both_dout_unchanged: got %h expected %h", d, model_dout); end
    access(1'b1, 1'b0, 32'h20, 32'h0, s, d); model_access(1'b1, 1'b0, 32'h20, 32'h0);
    n_checks++;
    if (d !== 32'h55) begin n_fail++; $display("FAIL both_load_data: got %h expected 00000055", d); end
  endtask

  // ram_cs stays high throughout, so each request starts the cycle after the previous DONE.
  task automatic test_back_to_back();
    int s; logic [31:0] d; logic [31:0] a; logic [31:0] v; int op; logic ren; logic wen;
    for (int k = 0; k < 8; k++) begin
      a = 32'(k * 4); v = $urandom();
      access(1'b0, 1'b1, a, v, s, d); model_access(1'b0, 1'b1, a, v);
      n_checks++;
      if (s != 2) begin n_fail++; $display("FAIL b2b_fill_stall[%0d]: got %0d expected 2", k, s); end
    end
    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 2));
      ren = (op != 1); wen = (op != 0);
      a   = ($urandom() & 32'hFFFFF000) | (32'($urandom_range(0, 7)) * 32'd4) | 32'($urandom_range(0, 3));
      v   = $urandom();
      access(ren, wen, a, v, s, d); model_access(ren, wen, a, v);
      n_checks++;
      if (s != (wen ? 2 : 3)) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %0d expected %0d", i, s, wen ? 2 : 3); end
      n_checks++;
      if (d !== model_dout) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %h expected %h", i, d, model_dout); end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_flush();
    test_freeze();
    test_async_reset();
    test_both_enables();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
